// File: rtl/aes_cipher_serializer.sv
// Captures the AES cipher block on the rising edge of done_in and streams it out as OUT_W-bit
// beats over valid/ready. Define AES_SERIALIZER_SKID_EN to add a 1-deep pending block register.
module aes_cipher_serializer #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_in,
  input  logic [DATA_W-1:0] cipher_in,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int unsigned Beats = DATA_W / OUT_W;
  localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  localparam logic StIdle  = 1'b0;
  localparam logic StShift = 1'b1;

  if (OUT_W == 0 || (DATA_W % OUT_W) != 0) begin : g_bad_width
    $error("aes_cipher_serializer: DATA_W must be an integer multiple of OUT_W");
  end

  logic              state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q;
  logic              ovf_q, ovf_d;
  logic              capture;
  logic              last_hs;
  logic              drop;
  logic [DATA_W-1:0] shifted;

`ifdef AES_SERIALIZER_SKID_EN
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
`endif

  assign capture = done_in & ~done_q;
  assign last_hs = (state_q == StShift) & out_ready & (cnt_q == LastCnt);
  assign shifted = (MSB_FIRST != 0) ? (shift_q << OUT_W) : (shift_q >> OUT_W);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    drop    = 1'b0;
`ifdef AES_SERIALIZER_SKID_EN
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
`endif
    case (state_q)
      StIdle: begin
        if (capture) begin
          shift_d = cipher_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      default: begin
        if (out_ready) begin
          shift_d = shifted;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            cnt_d = '0;
`ifdef AES_SERIALIZER_SKID_EN
            if (pend_full_q) begin
              shift_d     = pend_q;
              pend_full_d = capture;
              if (capture) pend_d = cipher_in;
            end else if (capture) begin
              shift_d = cipher_in;
            end else begin
              state_d = StIdle;
            end
`else
            if (capture) shift_d = cipher_in;
            else         state_d = StIdle;
`endif
          end
        end
        // Captures other than on the final handshake cannot reload the shifter.
        if (capture && !last_hs) begin
`ifdef AES_SERIALIZER_SKID_EN
          if (!pend_full_q) begin
            pend_d      = cipher_in;
            pend_full_d = 1'b1;
          end else begin
            drop = 1'b1;
          end
`else
          drop = 1'b1;
`endif
        end
      end
    endcase
  end

  assign ovf_d = drop | (ovf_q & ~ovf_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_in;
      ovf_q   <= ovf_d;
    end
  end

`ifdef AES_SERIALIZER_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end
`endif

  assign out_data  = (MSB_FIRST != 0) ? shift_q[DATA_W-1 -: OUT_W] : shift_q[OUT_W-1:0];
  assign out_valid = (state_q == StShift);
  assign busy      = (state_q == StShift);
  assign out_last  = (state_q == StShift) & (cnt_q == LastCnt);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_aes_cipher_serializer.sv
// Directed self-checking bench for aes_cipher_serializer (default 128/8, MSB first).
module tb_aes_cipher_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         done_in;
  logic [127:0] cipher_in;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         overflow;
  logic         ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] BlkA = 128'h29C3505F571420F6402299B31A02D73A;
  localparam logic [127:0] BlkB = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BlkC = 128'hDEADBEEF0123456789ABCDEFFEEDC0DE;

  aes_cipher_serializer #(
    .DATA_W   (128),
    .OUT_W    (8),
    .MSB_FIRST(1)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .done_in  (done_in),
    .cipher_in(cipher_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] beat_of(input logic [127:0] b, input int i);
    return b[127-8*i -: 8];
  endfunction

  task automatic start_block(input logic [127:0] blk);
    cipher_in = blk;
    done_in   = 1'b1;
    step();
    done_in   = 1'b0;
  endtask

  // Consume one block from the current cycle on; optional done rises at cycles inj_a/inj_b.
  task automatic recv_block(input logic [127:0] blk, input bit toggle, input bit hold,
                            input int inj_a, input logic [127:0] blk_a,
                            input int inj_b, input logic [127:0] blk_b, input int clr_at);
    int idx = 0;
    int cyc = 0;
    while (idx < 16 && cyc < 100) begin
      check("valid", out_valid, 1'b1);
      check($sformatf("beat%0d", idx), out_data, beat_of(blk, idx));
      check($sformatf("last%0d", idx), out_last, (idx == 15));
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      done_in   = hold || (cyc == inj_a) || (cyc == inj_b);
      if (cyc == inj_a) cipher_in = blk_a;
      if (cyc == inj_b) cipher_in = blk_b;
      ovf_clr = (cyc == clr_at);
      if (out_ready) idx++;
      cyc++;
      step();
    end
    ovf_clr   = 1'b0;
    out_ready = 1'b1;
    check("handshakes", idx, 16);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    rst = 1'b1; done_in = 1'b0; cipher_in = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    #1;
    step(); step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    step();

    // Basic stream with ready held high
    start_block(BlkA);
    check("first_29", out_data, 8'h29);
    recv_block(BlkA, 1'b0, 1'b0, -1, '0, -1, '0, -1);
    check("idle_valid", out_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("last_byte_3a", beat_of(BlkA, 15), 8'h3A);

    // Ready toggling
    step();
    start_block(BlkA);
    recv_block(BlkA, 1'b1, 1'b0, -1, '0, -1, '0, -1);
    check("tog_idle", out_valid, 1'b0);

    // done_in held high for 40 cycles streams one block only
    step();
    start_block(BlkB);
    done_in = 1'b1;
    recv_block(BlkB, 1'b0, 1'b1, -1, '0, -1, '0, -1);
    vcount = 0;
    for (int i = 0; i < 23; i++) begin
      if (out_valid) vcount++;
      step();
    end
    done_in = 1'b0;
    check("hold_one_block", vcount, 0);
    step();

    // done_in high across reset release
    rst = 1'b1; done_in = 1'b1;
    step(); step();
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) vcount++;
    end
    check("no_cap_rst", vcount, 0);
    done_in = 1'b0;
    step();

`ifndef AES_SERIALIZER_SKID_EN
    // Second rise at beat 5 is dropped and flags overflow
    start_block(BlkA);
    recv_block(BlkA, 1'b0, 1'b0, 5, BlkB, -1, '0, -1);
    check("drop_idle", out_valid, 1'b0);
    check("drop_ovf", overflow, 1'b1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 1'b0);
    start_block(BlkA);
    recv_block(BlkA, 1'b0, 1'b0, 3, BlkC, -1, '0, 3);
    check("set_wins", overflow, 1'b1);
`else
    // Second rise buffered and streamed back-to-back, third overflows
    start_block(BlkA);
    recv_block(BlkA, 1'b0, 1'b0, 3, BlkB, 8, BlkC, -1);
    check("skid_b2b", out_valid, 1'b1);
    recv_block(BlkB, 1'b0, 1'b0, -1, '0, -1, '0, -1);
    check("skid_idle", out_valid, 1'b0);
    check("skid_ovf", overflow, 1'b1);
`endif
    step();

    // Rise coinciding with the final handshake: no bubble
    start_block(BlkA);
    recv_block(BlkA, 1'b0, 1'b0, 15, BlkB, -1, '0, -1);
    done_in = 1'b0;
    check("nobubble_valid", out_valid, 1'b1);
    check("nobubble_data", out_data, 8'h00);
    recv_block(BlkB, 1'b0, 1'b0, -1, '0, -1, '0, -1);
    check("nobubble_idle", out_valid, 1'b0);
    step();

    // Reset mid-stream at beat 7
    start_block(BlkC);
    for (int i = 0; i < 7; i++) step();
    check("pre_rst_data", out_data, beat_of(BlkC, 7));
    rst = 1'b1;
    step();
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_last", out_last, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid) vcount++;
    end
    check("post_rst_quiet", vcount, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_cipher_serializer.md
Name: aes_cipher_serializer

Overview:
- Downstream of the AES core. Captures the 128-bit cipher_text when the core's done rises.
- Streams the captured block out as OUT_W-bit beats over a valid/ready interface toward a byte-wide transport (UART/FIFO).
- Decouples the AES core from a slow consumer and flags any block lost to back-pressure.

Parameters:
DATA_W, 128, width of the captured cipher block
OUT_W, 8, beat width; DATA_W must be an integer multiple of OUT_W (elaboration error otherwise)
MSB_FIRST, 1, 1 = first beat is cipher_in[DATA_W-1 -: OUT_W]; 0 = first beat is cipher_in[OUT_W-1:0]

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
done_in  input  1  AES core done; level signal, may stay high for many cycles
cipher_in  input  DATA_W  AES core cipher_text; valid whenever done_in is high
out_data  output  OUT_W  current beat
out_valid  output  1  beat valid
out_ready  input  1  consumer accepts beat when out_valid & out_ready
out_last  output  1  high with the final beat of a block
busy  output  1  high while in SHIFT state
overflow  output  1  sticky: a captured block was dropped
ovf_clr  input  1  clears overflow

Behaviour:
- BEATS = DATA_W/OUT_W (16 by default). Beat counter is $clog2(BEATS) bits and wraps to 0 after the last beat.
- Edge detect: done_q registers done_in. A capture event occurs when done_in & ~done_q.
- done_q resets to 1. A done_in held high through reset release produces no capture.
- Reset values:
  - out_valid=0, out_last=0, out_data=0, busy=0, overflow=0.
  - Shift register = 0, counter = 0, state = IDLE.
  - Pending register is empty.
- Reset mid-stream discards the block in flight; no partial beats appear afterwards.
- FSM, IDLE:
  - out_valid=0.
  - On a capture event at edge N: load shift register from cipher_in, counter=0, go to SHIFT.
  - First beat is valid in cycle N+1 (1-cycle latency).
- FSM, SHIFT:
  - out_valid=1, out_data = head beat of the shift register.
  - out_data and out_last are stable while out_valid & ~out_ready.
  - On handshake: shift by OUT_W toward the head, counter+1.
  - out_last = (counter == BEATS-1).
  - On a handshake with out_last: leave SHIFT. Go to IDLE, or reload per the capture rules below.
- Capture during SHIFT (feature off):
  - Capture coinciding with the final-beat handshake is accepted. The shift register reloads, counter=0, the FSM stays in SHIFT, and there is no bubble cycle.
  - Any other capture during SHIFT is dropped and sets overflow.
- overflow:
  - Set on a drop; cleared by ovf_clr.
  - A drop and ovf_clr in the same cycle leaves overflow = 1 (set wins).
- out_ready while out_valid=0 is ignored.
- Throughput: one beat per cycle with out_ready held high. A block takes BEATS cycles.

Optional Feature:
AES_SERIALIZER_SKID_EN
- Defined: adds a 1-deep pending block register.
  - A capture during SHIFT (not on the final handshake) with pending empty stores cipher_in in pending.
  - A capture with pending full sets overflow and is dropped.
  - On the final-beat handshake with pending full, pending moves to the shift register, counter=0, the FSM stays in SHIFT, and pending empties.
  - A capture coinciding with that handshake lands in pending.
- Undefined: no pending register; behaviour exactly as above.

Test Plan:
- Reset, then done_in rises with cipher_in=128'h29C3505F571420F6402299B31A02D73A and out_ready=1 -> out_valid from the next cycle; 16 beats 29,C3,50,5F,...,D7,3A; out_last only on 3A; busy=0 after the final beat.
- Same block with out_ready toggling 1,0,1,0 -> each beat held stable while stalled; 16 handshakes total; no byte repeated or skipped.
- done_in held high 40 cycles -> exactly one block streamed.
- done_in high across rst deassertion -> no capture; out_valid stays 0.
- Second done rise at beat 5, feature off -> overflow=1, first block completes intact. ovf_clr pulsed in the same cycle as a later drop -> overflow stays 1.
- Second done rise exactly on the final-beat handshake -> next cycle out_data is the new block's first beat with no idle cycle.
- With AES_SERIALIZER_SKID_EN, two rises during a stream -> the second is buffered and streamed back-to-back; the third sets overflow.
- rst asserted at beat 7 -> outputs return to reset values the next cycle.
